// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared widths, state encoding and start-index helper for mux_serializer
package ser_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic logic [SEL_W-1:0] start_idx(input logic msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - word-to-bit sequencer driving an external 8:1 mux
// Holds the word on mux_in, steps mux_sel and forwards mux_out as the serial bit.
module mux_serializer
  import ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              flush,
  output logic [WORD_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);

  ser_state_t        state;
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  cnt_q;
  logic              accept;
  logic              beat;

  assign ser_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign ser_last  = (state == SEND) && (cnt_q == 3'd7);
  assign ser_data  = mux_out;
  assign mux_in    = word_q;
  assign mux_sel   = sel_q;

  // Reloading on the last beat keeps back-to-back words free of bubbles.
  assign in_ready = !flush && ((state == IDLE) || (ser_last && ser_ready));
  assign accept   = in_valid && in_ready;
  assign beat     = ser_valid && ser_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      sel_q  <= START;
      cnt_q  <= '0;
    end else if (flush) begin
      state <= IDLE;
      sel_q <= START;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q <= in_data;
            sel_q  <= START;
            cnt_q  <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            if (cnt_q == 3'd7) begin
              if (accept) begin
                word_q <= in_data;
                sel_q  <= START;
                cnt_q  <= '0;
              end else begin
                state <= IDLE;
                sel_q <= START;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              sel_q <= MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - directed self-checking bench for mux_serializer
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       flush;
  logic       ser_ready;

  logic       in_ready0, ser_valid0, ser_data0, ser_last0, busy0, mux_out0;
  logic [7:0] mux_in0;
  logic [2:0] mux_sel0;
  logic       in_ready1, ser_valid1, ser_data1, ser_last1, busy1, mux_out1;
  logic [7:0] mux_in1;
  logic [2:0] mux_sel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The external 8:1 bit-select mux stages
  assign mux_out0 = mux_in0[mux_sel0];
  assign mux_out1 = mux_in1[mux_sel1];

  mux_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .mux_in(mux_in0), .mux_sel(mux_sel0),
    .mux_out(mux_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready),
    .ser_data(ser_data0), .ser_last(ser_last0), .busy(busy0)
  );

  mux_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .mux_in(mux_in1), .mux_sel(mux_sel1),
    .mux_out(mux_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready),
    .ser_data(ser_data1), .ser_last(ser_last1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; ser_ready = 1'b1;
    tick();
    tick();
    obs = {in_ready0, ser_valid0, ser_last0, busy0, mux_in0, mux_sel0};
    checks++;
    if (obs !== 15'b1_0_0_0_00000000_000) begin
      errors++;
      $display("FAIL reset_lsb: got %b expected %b", obs, 15'b1_0_0_0_00000000_000);
    end
    checks++;
    if (mux_sel1 !== 3'd7) begin
      errors++;
      $display("FAIL reset_msb_sel: got %0d expected 7", mux_sel1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'hA5;
    logic [5:0] obs, exp;
    load_word(w);
    for (int i = 0; i < 8; i++) begin
      obs = {ser_valid0, ser_last0, mux_sel0, ser_data0};
      exp = {1'b1, (i == 7), i[2:0], w[i]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lsb_beat%0d: got %b expected %b", i, obs, exp);
      end
      checks++;
      if (mux_in0 !== w) begin
        errors++;
        $display("FAIL lsb_mux_in%0d: got %h expected %h", i, mux_in0, w);
      end
      tick();
    end
    checks++;
    if ({busy0, ser_valid0, in_ready0} !== 3'b001) begin
      errors++;
      $display("FAIL lsb_end: got %b expected 001", {busy0, ser_valid0, in_ready0});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'h80;
    logic [5:0] obs, exp;
    logic [2:0] s;
    load_word(w);
    for (int i = 0; i < 8; i++) begin
      s = 3'(7 - i);
      obs = {ser_valid1, ser_last1, mux_sel1, ser_data1};
      exp = {1'b1, (i == 7), s, (i == 0)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL msb_beat%0d: got %b expected %b", i, obs, exp);
      end
      tick();
    end
    checks++;
    if ({busy1, mux_sel1} !== 4'b0111) begin
      errors++;
      $display("FAIL msb_end: got %b expected 0111", {busy1, mux_sel1});
    end
  endtask

  task automatic test_stall();
    logic [7:0] w = 8'h3C;
    logic [5:0] obs, exp;
    load_word(w);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          obs = {ser_valid0, ser_last0, mux_sel0, ser_data0};
          checks++;
          if (obs !== 6'b1_0_010_1) begin
            errors++;
            $display("FAIL stall_hold%0d: got %b expected %b", k, obs, 6'b1_0_010_1);
          end
          tick();
        end
        ser_ready = 1'b1;
      end
      obs = {ser_valid0, ser_last0, mux_sel0, ser_data0};
      exp = {1'b1, (i == 7), i[2:0], w[i]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stall_beat%0d: got %b expected %b", i, obs, exp);
      end
      tick();
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got busy %b expected 0", busy0);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs, exp;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_data = 8'h00;
    for (int k = 0; k < 16; k++) begin
      obs = {in_ready0, ser_valid0, ser_last0, mux_sel0, ser_data0};
      exp = {(k == 7 || k == 15), 1'b1, (k == 7 || k == 15), 3'(k % 8), (k < 8)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %b expected %b", k, obs, exp);
      end
      tick();
      if (k == 7) in_valid = 1'b0;
    end
    checks++;
    if ({busy0, ser_valid0} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: got %b expected 00", {busy0, ser_valid0});
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] w = 8'h0F;
    logic [4:0] obs, exp;
    load_word(8'hF0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ser_valid0, busy0, mux_sel0, in_ready0} !== 6'b0_0_000_1) begin
      errors++;
      $display("FAIL async_rst: got %b expected %b", {ser_valid0, busy0, mux_sel0, in_ready0}, 6'b0_0_000_1);
    end
    checks++;
    if (mux_in0 !== 8'h00) begin
      errors++;
      $display("FAIL async_rst_word: got %h expected 00", mux_in0);
    end
    #1;
    rst = 1'b0;
    load_word(w);
    for (int i = 0; i < 8; i++) begin
      obs = {ser_valid0, mux_sel0, ser_data0};
      exp = {1'b1, i[2:0], w[i]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_rst_beat%0d: got %b expected %b", i, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [7:0] w = 8'h99;
    logic [5:0] obs, exp;
    load_word(8'h55);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ser_last0, ser_data0} !== {1'b0, (i % 2 == 0)}) begin
        errors++;
        $display("FAIL flush_pre%0d: got %b expected %b", i, {ser_last0, ser_data0}, {1'b0, (i % 2 == 0)});
      end
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = w;
    #1;
    checks++;
    if ({in_ready0, ser_last0} !== 2'b00) begin
      errors++;
      $display("FAIL flush_cycle: got %b expected 00", {in_ready0, ser_last0});
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({busy0, ser_valid0, ser_last0, in_ready0, mux_sel0} !== 7'b0_0_0_1_000) begin
      errors++;
      $display("FAIL flush_idle: got %b expected %b", {busy0, ser_valid0, ser_last0, in_ready0, mux_sel0}, 7'b0_0_0_1_000);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {ser_valid0, ser_last0, mux_sel0, ser_data0};
      exp = {1'b1, (i == 7), i[2:0], w[i]};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL flush_next_beat%0d: got %b expected %b", i, obs, exp);
      end
      tick();
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_end: got busy %b expected 0", busy0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
